// File: rtl/divide_compute_pynq_pkg.sv
// divide_pkg: shared state encoding and sizing helpers for the sequential divider.
package divide_pkg;
    localparam int DW_DEF = 32;
    localparam int CNT_W = $clog2(DW_DEF);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
    function automatic int cnt_w(input int dw);
        return $clog2(dw);
    endfunction
endpackage

// File: rtl/divide_compute_pynq_if.sv
// divide_compute_pynq_if: PYNQ start/ready register handshake plus operands and results.
// perf_count is present only when DIVIDE_PERF_CNT_EN is defined.
interface divide_compute_pynq_if #(parameter int DATA_WIDTH = 32);
    logic                    start;
    logic [2*DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0]   divisor;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic                    ready;
    logic                    busy;
    logic                    div_by_zero;
    logic                    overflow;
`ifdef DIVIDE_PERF_CNT_EN
    logic [31:0]             perf_count;
    modport master (output start, dividend, divisor,
                    input quotient, remainder, ready, busy, div_by_zero, overflow, perf_count);
    modport slave (input start, dividend, divisor,
                   output quotient, remainder, ready, busy, div_by_zero, overflow, perf_count);
`else
    modport master (output start, dividend, divisor,
                    input quotient, remainder, ready, busy, div_by_zero, overflow);
    modport slave (input start, dividend, divisor,
                   output quotient, remainder, ready, busy, div_by_zero, overflow);
`endif
endinterface

// File: rtl/divide_compute_pynq_step.sv
// divide_step: one combinational restoring-division iteration, carry kept in a DW+1 compare.
module divide_step
    import divide_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEF
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  bit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_next_o,
    output logic                  q_bit_o
);
    logic [DATA_WIDTH:0] sh;
    assign sh = {rem_i, bit_i};
    assign q_bit_o = sh >= {1'b0, divisor_i};
    // rem < divisor holds on entry, so the restored/subtracted value always fits DW bits
    assign rem_next_o = DATA_WIDTH'(q_bit_o ? sh - {1'b0, divisor_i} : sh);
endmodule

// File: rtl/divide_compute_pynq.sv
// divide_compute_pynq: sequential 2*DW / DW unsigned restoring divider behind a start/ready handshake.
// Define DIVIDE_PERF_CNT_EN to add the perf_count completion counter.
module divide_compute_pynq
    import divide_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEF
) (
    input logic                   clk,
    input logic                   reset,
    divide_compute_pynq_if.slave  dif
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_w(DW);
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d, shr_q, shr_d, dvs_q, dvs_d;
    logic [DW-1:0]   quo_q, quo_d, rmd_q, rmd_d;
    logic            rdy_q, rdy_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [DW-1:0]   step_rem, hi, lo;
    logic            step_q;
    assign hi = dif.dividend[2*DW-1:DW];
    assign lo = dif.dividend[DW-1:0];
    divide_step #(.DATA_WIDTH(DW)) u_step (
        .rem_i      (rem_q),
        .bit_i      (shr_q[DW-1]),
        .divisor_i  (dvs_q),
        .rem_next_o (step_rem),
        .q_bit_o    (step_q)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shr_d   = shr_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        rdy_d   = rdy_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (dif.start) begin
                dvs_d = dif.divisor;
                rdy_d = 1'b0;
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                if (dif.divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = lo;
                    dbz_d   = 1'b1;
                    rdy_d   = 1'b1;
                end else if (hi >= dif.divisor) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = '0;
                    ovf_d   = 1'b1;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = RUN;
                    rem_d   = hi;
                    shr_d   = lo;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // quotient bits shift into the vacated low end of the dividend register
                rem_d = step_rem;
                shr_d = {shr_q[DW-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                    quo_d   = {shr_q[DW-2:0], step_q};
                    rmd_d   = step_rem;
                    rdy_d   = 1'b1;
                end
            end
            DONE: if (!dif.start) begin
                state_d = IDLE;
                rdy_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shr_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            rdy_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shr_q   <= shr_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            rdy_q   <= rdy_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end
    assign dif.quotient    = quo_q;
    assign dif.remainder   = rmd_q;
    assign dif.ready       = rdy_q;
    assign dif.busy        = state_q == RUN;
    assign dif.div_by_zero = dbz_q;
    assign dif.overflow    = ovf_q;
`ifdef DIVIDE_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else if (state_d == DONE && state_q != DONE) perf_q <= perf_q + 1'b1;
    end
    assign dif.perf_count = perf_q;
`endif
endmodule

// File: tb/tb_divide_compute_pynq.sv
// tb_divide_compute_pynq: directed vectors with hand-computed results for the sequential divider.
module tb_divide_compute_pynq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int lat, busy_n;
    always #5 clk = ~clk;
    divide_compute_pynq_if #(.DATA_WIDTH(32)) dif ();
    divide_compute_pynq #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif.slave)
    );
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask
    task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic dz, input logic ov);
        check({tag, "_q"}, 64'(dif.quotient), 64'(q));
        check({tag, "_r"}, 64'(dif.remainder), 64'(r));
        check({tag, "_dbz"}, 64'(dif.div_by_zero), 64'(dz));
        check({tag, "_ovf"}, 64'(dif.overflow), 64'(ov));
    endtask
    // lat counts edges from the accept edge (inclusive) until ready is seen
    task automatic run_op(input logic [63:0] dd, input logic [31:0] dv);
        @(negedge clk);
        dif.dividend = dd;
        dif.divisor  = dv;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        busy_n = int'(dif.busy);
        while (!dif.ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (dif.busy) busy_n++;
        end
    endtask
    task automatic drop_start(input string tag);
        @(negedge clk);
        dif.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rdy_drop"}, 64'(dif.ready), 64'd0);
    endtask
    initial begin
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(dif.ready), 64'd0);
        check("rst_busy", 64'(dif.busy), 64'd0);
        check_res("rst", 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_op(64'd100, 32'd7);
        check("t1_lat", 64'(lat), 64'd33);
        check("t1_busy_cycles", 64'(busy_n), 64'd32);
        check("t1_busy_end", 64'(dif.busy), 64'd0);
        check_res("t1", 32'd14, 32'd2, 1'b0, 1'b0);
        drop_start("t1");
        check("t1_held_q", 64'(dif.quotient), 64'd14);
        run_op(64'd5, 32'd0);
        check("t2_lat", 64'(lat), 64'd1);
        check_res("t2", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        drop_start("t2");
        check("t2_held_dbz", 64'(dif.div_by_zero), 64'd1);
        run_op(64'h0000_0001_0000_0000, 32'd1);
        check("t3_lat", 64'(lat), 64'd1);
        check_res("t3", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        drop_start("t3");
        run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        check("t4_lat", 64'(lat), 64'd33);
        check_res("t4", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        drop_start("t4");
        @(negedge clk);
        dif.dividend = 64'd100;
        dif.divisor = 32'd7;
        dif.start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rdy", 64'(dif.ready), 64'd0);
        check("t5_busy", 64'(dif.busy), 64'd0);
        check_res("t5", 32'd0, 32'd0, 1'b0, 1'b0);
        check("t5_state", 64'(dut.state_q), 64'd0);
        dif.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_op(64'd100, 32'd7);
        check("t5b_lat", 64'(lat), 64'd33);
        check_res("t5b", 32'd14, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        dif.dividend = 64'd81;
        dif.divisor = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t6_hold_rdy", 64'(dif.ready), 64'd1);
            check("t6_hold_busy", 64'(dif.busy), 64'd0);
        end
        check("t6_hold_q", 64'(dif.quotient), 64'd14);
        drop_start("t6");
        run_op(64'd81, 32'd9);
        check("t6_lat", 64'(lat), 64'd33);
        check_res("t6", 32'd9, 32'd0, 1'b0, 1'b0);
`ifdef DIVIDE_PERF_CNT_EN
        check("t6_perf", 64'(dif.perf_count), 64'd2);
`endif
        drop_start("t6b");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
